regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined RISC-V core; next generation of the 2R/1W file.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_mp_if.sv | 40 ++++
 rtl/regfile_clr_fsm.sv | 72 +++++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// No logic: enums, default sizes and the address-width helper.
// No handshake; pure compile-time content.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRP_DEF  = 2;
    localparam int NWP_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Address width for nreg registers; at least 1 so a 2-entry file still has an address bit.
    function automatic int clog2_aw(input int nreg);
        int aw;
        aw = 1;
        while ((1 << aw) < nreg) aw = aw + 1;
        return aw;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of ID/WB-facing register file signals (reads, writes, issue, clear, debug).
// Latency: none, plain wires.
// Backpressure: clr_busy tells the core that writes/issues are being dropped.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = NRP_DEF,
    parameter int NWP  = NWP_DEF
) ();
    localparam int AW = clog2_aw(NREG);

    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd;
    logic [NRP-1:0]      rd_busy;
    logic [NWP-1:0]      we;
    logic [NWP*AW-1:0]   wa;
    logic [NWP*XLEN-1:0] wd;
    logic                iss_vld;
    logic [AW-1:0]       iss_rd;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    logic [AW-1:0]       dbg_sel;
    logic [XLEN-1:0]     dbg_data;

    // Core side: drives addresses, writes, issue and clear request.
    modport master (
        output ra, we, wa, wd, iss_vld, iss_rd, clr_req, dbg_sel,
        input  rd, rd_busy, clr_busy, clr_done, dbg_data
    );

    // Register file side.
    modport slave (
        input  ra, we, wa, wd, iss_vld, iss_rd, clr_req, dbg_sel,
        output rd, rd_busy, clr_busy, clr_done, dbg_data
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: sweeps x1..x(NREG-1) to zero, one register per cycle.
// Latency: clr_busy from the edge after the request, clr_done pulses NREG cycles after it.
// Backpressure: requests while busy are ignored; busy_flush fires on the accepting edge.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = clog2_aw(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clear_we,
    output logic [AW-1:0] clear_idx,
    output logic          busy_flush
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    clr_state_t    state;
    logic [AW-1:0] idx;

    // Scoreboard wipe must land on the same edge that accepts the request, so it is a decode, not a register.
    assign busy_flush = (state == IDLE) && clr_req;
    assign clear_idx  = idx;

    // Sequencer state and registered status outputs; idx holds at the last register so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            clear_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        idx      <= AW'(1);
                        clr_busy <= 1'b1;
                        clear_we <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        clear_we <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    idx      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    clear_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard, debug read and soft clear.
// Latency: reads combinational, writes visible next cycle (same cycle with REGFILE_WRITE_BYPASS_EN).
// Backpressure: none on ports; writes and issues are dropped while clr_busy is high.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = NRP_DEF,
    parameter int NWP  = NWP_DEF
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = clog2_aw(NREG);

    logic [XLEN-1:0] rf       [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   wa_a     [NWP];
    logic [XLEN-1:0] wd_a     [NWP];
    logic [NWP-1:0]  wr_acc;
    logic            iss_acc;
    logic [AW-1:0]   la       [NRP+1];
    logic [XLEN-1:0] ld       [NRP+1];
    logic            clr_busy;
    logic            clr_done;
    logic            clear_we;
    logic [AW-1:0]   clear_idx;
    logic            busy_flush;

    regfile_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (bus.clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clear_we   (clear_we),
        .clear_idx  (clear_idx),
        .busy_flush (busy_flush)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // Unpack write ports and qualify them: x0 targets and anything during a clear are dropped.
    always_comb begin
        wr_acc  = '0;
        iss_acc = bus.iss_vld && (bus.iss_rd != '0) && !clr_busy;
        for (int j = 0; j < NWP; j++) begin
            wa_a[j]   = bus.wa[j*AW +: AW];
            wd_a[j]   = bus.wd[j*XLEN +: XLEN];
            wr_acc[j] = bus.we[j] && (wa_a[j] != '0) && !clr_busy;
        end
    end

    // Next scoreboard: writes retire producers, then a same-edge issue re-marks (newer producer wins).
    always_comb begin
        busy_nxt = busy;
        if (busy_flush) begin
            busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWP; j++)
                if (wr_acc[j]) busy_nxt[wa_a[j]] = 1'b0;
            if (iss_acc) busy_nxt[bus.iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Storage: clear sweep or port writes; later ports overwrite earlier ones on a shared address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) rf[r] <= '0;
        end else if (clear_we) begin
            rf[clear_idx] <= '0;
        end else begin
            for (int j = 0; j < NWP; j++)
                if (wr_acc[j]) rf[wa_a[j]] <= wd_a[j];
        end
    end

    // Lookup addresses: read ports first, debug port last.
    always_comb begin
        la = '{default: '0};
        for (int i = 0; i < NRP; i++) la[i] = bus.ra[i*AW +: AW];
        la[NRP] = bus.dbg_sel;
    end

    // Data lookup for read and debug ports, with optional same-cycle write forwarding.
    always_comb begin
        ld = '{default: '0};
        for (int k = 0; k <= NRP; k++) begin
            ld[k] = (la[k] == '0) ? '0 : rf[la[k]];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int j = 0; j < NWP; j++)
                if (wr_acc[j] && (wa_a[j] == la[k])) ld[k] = wd_a[j];
`endif
        end
    end

    // Drive read data and busy flags; a forwarded read reports the post-edge busy bit.
    always_comb begin
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            bus.rd[i*XLEN +: XLEN] = ld[i];
            bus.rd_busy[i]         = busy[la[i]];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int j = 0; j < NWP; j++)
                if (wr_acc[j] && (wa_a[j] == la[i])) bus.rd_busy[i] = busy_nxt[la[i]];
`endif
            if (la[i] == '0) bus.rd_busy[i] = 1'b0;
        end
    end

    assign bus.dbg_data = ld[NRP];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for port behaviour plus clear/reset/bypass sequences.
// Inputs driven just after the rising edge, outputs sampled 1 time unit later.
// Each comparison prints a FAIL line on mismatch and the run ends with one summary line.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  iss_rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_b0;
        logic        e_b1;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we      = '0;
        bus.wa      = '0;
        bus.wd      = '0;
        bus.iss_vld = 1'b0;
        bus.iss_rd  = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic write0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 2'b01;
        bus.wa = {5'd0, a};
        bus.wd = {32'd0, d};
        tick();
        bus.we = '0;
    endtask

    int  k;
    logic done_seen;
    logic busy_seen;

    initial begin
        // Vector table: one write/issue edge, then read back with ports idle.
        vt[0] = '{2'b11, 5'd5,  5'd5,  32'h11,   32'h22,   1'b0, 5'd0,  5'd5, 5'd0,  32'h22,   32'h0,    1'b0, 1'b0};
        vt[1] = '{2'b01, 5'd0,  5'd0,  32'hFF,   32'h0,    1'b0, 5'd0,  5'd0, 5'd5,  32'h0,    32'h22,   1'b0, 1'b0};
        vt[2] = '{2'b10, 5'd0,  5'd0,  32'h0,    32'hFF,   1'b1, 5'd0,  5'd0, 5'd0,  32'h0,    32'h0,    1'b0, 1'b0};
        vt[3] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,    1'b1, 5'd7,  5'd7, 5'd5,  32'h0,    32'h22,   1'b1, 1'b0};
        vt[4] = '{2'b01, 5'd7,  5'd0,  32'hA5,   32'h0,    1'b0, 5'd0,  5'd7, 5'd7,  32'hA5,   32'hA5,   1'b0, 1'b0};
        vt[5] = '{2'b10, 5'd0,  5'd7,  32'h0,    32'h5A,   1'b1, 5'd7,  5'd7, 5'd5,  32'h5A,   32'h22,   1'b1, 1'b0};
        vt[6] = '{2'b11, 5'd9,  5'd10, 32'h99,   32'h1010, 1'b1, 5'd9,  5'd9, 5'd10, 32'h99,   32'h1010, 1'b1, 1'b0};
        vt[7] = '{2'b11, 5'd7,  5'd7,  32'h77,   32'h88,   1'b0, 5'd0,  5'd7, 5'd9,  32'h88,   32'h99,   1'b0, 1'b1};
        vt[8] = '{2'b01, 5'd9,  5'd0,  32'h9999, 32'h0,    1'b1, 5'd10, 5'd9, 5'd10, 32'h9999, 32'h1010, 1'b0, 1'b1};

        rst_n = 1'b0;
        idle_inputs();
        set_ra(5'd0, 5'd0);
        bus.dbg_sel = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // Preload, then async reset must zero everything without a clock edge.
        bus.we      = 2'b01;
        bus.wa      = {5'd0, 5'd5};
        bus.wd      = {32'd0, 32'hAB};
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd6;
        tick();
        idle_inputs();
        set_ra(5'd5, 5'd6);
        bus.dbg_sel = 5'd5;
        #1;
        chk("preload_rd0", bus.rd[31:0], 32'hAB);
        chk("preload_busy1", {31'd0, bus.rd_busy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd0", bus.rd[31:0], 32'h0);
        chk("rst_rd1", bus.rd[63:32], 32'h0);
        chk("rst_busy", {30'd0, bus.rd_busy}, 32'h0);
        chk("rst_clr_busy", {31'd0, bus.clr_busy}, 32'h0);
        chk("rst_clr_done", {31'd0, bus.clr_done}, 32'h0);
        chk("rst_dbg", bus.dbg_data, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        // Table-driven port behaviour.
        for (int v = 0; v < 9; v++) begin
            bus.we      = vt[v].we;
            bus.wa      = {vt[v].wa1, vt[v].wa0};
            bus.wd      = {vt[v].wd1, vt[v].wd0};
            bus.iss_vld = vt[v].iss;
            bus.iss_rd  = vt[v].iss_rd;
            tick();
            idle_inputs();
            set_ra(vt[v].ra0, vt[v].ra1);
            bus.dbg_sel = vt[v].ra1;
            #1;
            chk($sformatf("vec%0d_rd0", v), bus.rd[31:0], vt[v].e_rd0);
            chk($sformatf("vec%0d_rd1", v), bus.rd[63:32], vt[v].e_rd1);
            chk($sformatf("vec%0d_busy0", v), {31'd0, bus.rd_busy[0]}, {31'd0, vt[v].e_b0});
            chk($sformatf("vec%0d_busy1", v), {31'd0, bus.rd_busy[1]}, {31'd0, vt[v].e_b1});
            chk($sformatf("vec%0d_dbg", v), bus.dbg_data, vt[v].e_rd1);
        end

        // Same-cycle write/read of x10 (stored 0x1010, busy): forwarded only with the bypass build.
        tick();
        bus.we = 2'b01;
        bus.wa = {5'd0, 5'd10};
        bus.wd = {32'd0, 32'h1234};
        set_ra(5'd10, 5'd0);
        bus.dbg_sel = 5'd10;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("byp_rd0", bus.rd[31:0], 32'h1234);
        chk("byp_busy0", {31'd0, bus.rd_busy[0]}, 32'd0);
        chk("byp_dbg", bus.dbg_data, 32'h1234);
`else
        chk("byp_rd0", bus.rd[31:0], 32'h1010);
        chk("byp_busy0", {31'd0, bus.rd_busy[0]}, 32'd1);
        chk("byp_dbg", bus.dbg_data, 32'h1010);
`endif
        tick();
        idle_inputs();
        #1;
        chk("byp_after_rd0", bus.rd[31:0], 32'h1234);
        chk("byp_after_busy0", {31'd0, bus.rd_busy[0]}, 32'd0);

        // Soft clear: fill, mark x4 busy, request, watch the full sequence.
        for (int r = 1; r < NREG; r++) write0(5'(r), 32'hDEAD);
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd4;
        tick();
        idle_inputs();
        bus.clr_req = 1'b1;
        tick();
        for (k = 1; k <= 34; k++) begin
            idle_inputs();
            set_ra(5'd1, 5'd4);
            if (k == 3) set_ra(5'd1, 5'd31);
            if (k == 5) begin
                bus.we      = 2'b01;
                bus.wa      = {5'd0, 5'd1};
                bus.wd      = {32'd0, 32'hBAD};
                bus.iss_vld = 1'b1;
                bus.iss_rd  = 5'd2;
            end
            if (k == 10) bus.clr_req = 1'b1;
            #1;
            chk($sformatf("clr_busy_k%0d", k), {31'd0, bus.clr_busy}, (k <= 32) ? 32'd1 : 32'd0);
            chk($sformatf("clr_done_k%0d", k), {31'd0, bus.clr_done}, (k == 32) ? 32'd1 : 32'd0);
            if (k == 1) chk("clr_flush_busy4", {31'd0, bus.rd_busy[1]}, 32'd0);
            if (k == 3) begin
                chk("clr_partial_x1", bus.rd[31:0], 32'h0);
                chk("clr_partial_x31", bus.rd[63:32], 32'hDEAD);
            end
            tick();
        end
        idle_inputs();
        for (int r = 1; r < NREG; r++) begin
            set_ra(5'(r), 5'd2);
            #1;
            chk($sformatf("clr_x%0d", r), bus.rd[31:0], 32'h0);
        end
        chk("clr_drop_iss_x2", {31'd0, bus.rd_busy[1]}, 32'd0);

        // Reset in the middle of a clear: abort with no done pulse, ports usable afterwards.
        write0(5'd20, 32'h2020);
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd12;
        tick();
        idle_inputs();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        set_ra(5'd20, 5'd12);
        bus.dbg_sel = 5'd20;
        #1;
        chk("mid_pre_x20", bus.rd[31:0], 32'h2020);
        rst_n = 1'b0;
        #1;
        chk("mid_clr_busy", {31'd0, bus.clr_busy}, 32'd0);
        chk("mid_clr_done", {31'd0, bus.clr_done}, 32'd0);
        chk("mid_x20", bus.rd[31:0], 32'h0);
        chk("mid_dbg", bus.dbg_data, 32'h0);
        #1;
        rst_n = 1'b1;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 35; c++) begin
            tick();
            done_seen = done_seen | bus.clr_done;
            busy_seen = busy_seen | bus.clr_busy;
        end
        chk("mid_no_done", {31'd0, done_seen}, 32'd0);
        chk("mid_no_busy", {31'd0, busy_seen}, 32'd0);
        chk("mid_busy12", {31'd0, bus.rd_busy[1]}, 32'd0);
        write0(5'd20, 32'h55);
        #1;
        chk("mid_after_x20", bus.rd[31:0], 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
